// File: rtl/lvds_clk_fwd_gen.sv
// lvds_clk_fwd_gen: forwarded-clock generator for an external OBUFDS pair.
// It produces a glitch-free 50%-duty clock on clk_out whose half-period is
// programmable in fabric-clock cycles. It can run continuously or for a fixed
// number of periods. Divisor changes and stop requests only ever take effect
// on a period boundary, so clk_out never carries a runt pulse.
`timescale 1ns/1ps

module lvds_clk_fwd_gen #(
  parameter int DIV_W        = 16,
  parameter int BURST_W      = 16,
  parameter int DEFAULT_HALF = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIV_W-1:0]   half_div,
  input  logic               div_load,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               running,
  output logic               period_tick,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // A zero half-period would never let the half counter terminate, so the
  // reset divisor is clamped the same way a loaded divisor is.
  localparam int RESET_HALF = (DEFAULT_HALF < 1) ? 1 : DEFAULT_HALF;
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(RESET_HALF);

  state_t             state;
  logic [DIV_W-1:0]   pending_div;
  logic [DIV_W-1:0]   active_div;
  logic [DIV_W-1:0]   hcnt;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] pcnt;
  logic               stop_pend;

  logic [DIV_W-1:0]   load_val;
  logic [DIV_W-1:0]   start_div;
  logic [BURST_W-1:0] pcnt_next;
  logic               half_end;
  logic               burst_end;
  logic               end_run;

  // Decode the divisor request and the end-of-half / end-of-run conditions.
  // A stop arriving on the final LOW cycle is honoured at that same boundary.
  always_comb begin
    load_val  = (half_div == '0) ? DIV_W'(1) : half_div;
    start_div = div_load ? load_val : pending_div;
    half_end  = (hcnt == (active_div - DIV_W'(1)));
    pcnt_next = pcnt + BURST_W'(1);
    burst_end = (burst != '0) && (pcnt_next == burst);
    end_run   = stop_pend || stop || burst_end;
  end

  // Pending divisor: captured on every div_load, whatever the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_div <= RESET_DIV;
    end else if (div_load) begin
      pending_div <= load_val;
    end
  end

  // Output FSM: every output is a register, so clk_out leaves the block
  // straight from a flop and cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      active_div  <= RESET_DIV;
      burst       <= '0;
      pcnt        <= '0;
      hcnt        <= '0;
      stop_pend   <= 1'b0;
      clk_out     <= 1'b0;
      running     <= 1'b0;
      period_tick <= 1'b0;
      done        <= 1'b0;
    end else begin
      period_tick <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          clk_out <= 1'b0;
          running <= 1'b0;
          if (start) begin
            active_div  <= start_div;
            burst       <= burst_len;
            pcnt        <= '0;
            hcnt        <= '0;
            stop_pend   <= 1'b0;
            state       <= HIGH;
            clk_out     <= 1'b1;
            running     <= 1'b1;
            period_tick <= 1'b1;
          end
        end

        HIGH: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (half_end) begin
            hcnt    <= '0;
            state   <= LOW;
            clk_out <= 1'b0;
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end

        LOW: begin
          if (stop) begin
            stop_pend <= 1'b1;
          end
          if (half_end) begin
            hcnt <= '0;
            pcnt <= pcnt_next;
            if (end_run) begin
              state     <= IDLE;
              running   <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end else begin
              active_div  <= pending_div;
              state       <= HIGH;
              clk_out     <= 1'b1;
              period_tick <= 1'b1;
            end
          end else begin
            hcnt <= hcnt + DIV_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          clk_out <= 1'b0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_clk_fwd_gen.sv
// tb_lvds_clk_fwd_gen: directed scenarios plus a randomized run. The
// reference model describes the output as a position within a period of
// 2*div cycles: high for the first div cycles, a tick at position 0.
`timescale 1ns/1ps

module tb_lvds_clk_fwd_gen;

  localparam int DEF_HALF = 8;

  logic        clk;
  logic        rst;
  logic [15:0] half_div;
  logic        div_load;
  logic [15:0] burst_len;
  logic        start;
  logic        stop;
  logic        clk_out;
  logic        running;
  logic        period_tick;
  logic        done;

  int n_cmp;
  int n_err;

  // reference model state
  bit m_run;
  int m_pos;
  int m_div;
  int m_pend;
  int m_periods;
  int m_burst;
  bit m_stopreq;
  bit m_done;

  lvds_clk_fwd_gen #(
    .DIV_W(16),
    .BURST_W(16),
    .DEFAULT_HALF(DEF_HALF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .half_div(half_div),
    .div_load(div_load),
    .burst_len(burst_len),
    .start(start),
    .stop(stop),
    .clk_out(clk_out),
    .running(running),
    .period_tick(period_tick),
    .done(done)
  );

  // fabric clock, 10 ns period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // global time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // advance the model by one clk edge using the inputs seen at that edge
  task automatic model_step();
    int eff;
    eff = (half_div == 16'd0) ? 1 : int'(half_div);
    m_done = 1'b0;
    if (rst) begin
      m_run     = 1'b0;
      m_pos     = 0;
      m_div     = DEF_HALF;
      m_pend    = DEF_HALF;
      m_periods = 0;
      m_burst   = 0;
      m_stopreq = 1'b0;
    end else begin
      if (!m_run) begin
        if (start) begin
          m_div     = div_load ? eff : m_pend;
          m_burst   = int'(burst_len);
          m_periods = 0;
          m_stopreq = 1'b0;
          m_pos     = 0;
          m_run     = 1'b1;
        end
      end else begin
        if (stop) m_stopreq = 1'b1;
        if (m_pos == 2 * m_div - 1) begin
          m_periods++;
          if (m_stopreq || (m_burst != 0 && (m_periods % 65536) == m_burst)) begin
            m_run     = 1'b0;
            m_done    = 1'b1;
            m_stopreq = 1'b0;
            m_pos     = 0;
          end else begin
            m_div = m_pend;
            m_pos = 0;
          end
        end else begin
          m_pos++;
        end
      end
      if (div_load) m_pend = eff;
    end
  endtask

  function automatic logic [3:0] model_vec();
    logic [3:0] v;
    v[3] = m_run && (m_pos < m_div);
    v[2] = m_run;
    v[1] = m_run && (m_pos == 0);
    v[0] = m_done;
    return v;
  endfunction

  // one clk cycle: edge, model update, settle, then drop one-cycle pulses
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    start    = 1'b0;
    stop     = 1'b0;
    div_load = 1'b0;
  endtask

  // run until done pulses or the budget expires; reports whether it was seen
  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    logic       exp_clk;
    rst = 1'b1;
    cycle();
    cycle();
    obs = {clk_out, running, period_tick, done};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got %b want 0000", obs);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      obs = {clk_out, running, period_tick, done};
      n_cmp++;
      if (obs !== 4'b0000 || obs !== model_vec()) begin
        n_err++;
        $display("[TB] FAIL idle_quiet[%0d]: got %b want 0000", i, obs);
      end
    end
    burst_len = 16'd1;
    start = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      cycle();
      exp_clk = (i <= 8);
      n_cmp++;
      if (clk_out !== exp_clk) begin
        n_err++;
        $display("[TB] FAIL default_half[%0d]: clk_out %b want %b", i, clk_out, exp_clk);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || running !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL default_done: done %b running %b want 1 0", done, running);
    end
  endtask

  task automatic test_continuous();
    logic exp_clk;
    logic exp_tick;
    bit   seen;
    half_div = 16'd2;
    div_load = 1'b1;
    cycle();
    burst_len = 16'd0;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      exp_clk  = ((i % 4) < 2);
      exp_tick = ((i % 4) == 0);
      n_cmp++;
      if (clk_out !== exp_clk || period_tick !== exp_tick || running !== 1'b1) begin
        n_err++;
        $display("[TB] FAIL continuous[%0d]: clk_out %b tick %b running %b want %b %b 1",
                 i, clk_out, period_tick, running, exp_clk, exp_tick);
      end
    end
    stop = 1'b1;
    wait_done(20, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL continuous_stop: done seen %b want 1", seen);
    end
  endtask

  task automatic test_burst();
    logic [8:0] seq;
    int run_cycles;
    int done_count;
    int done_at;
    seq = 9'b000101010;
    run_cycles = 0;
    done_count = 0;
    done_at = 0;
    half_div = 16'd1;
    div_load = 1'b1;
    cycle();
    burst_len = 16'd3;
    start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      n_cmp++;
      if (clk_out !== seq[i]) begin
        n_err++;
        $display("[TB] FAIL burst_clk[%0d]: clk_out %b want %b", i, clk_out, seq[i]);
      end
      if (running) run_cycles++;
      if (done) begin
        done_count++;
        done_at = i;
      end
    end
    n_cmp++;
    if (run_cycles != 6 || done_count != 1 || done_at != 7) begin
      n_err++;
      $display("[TB] FAIL burst_summary: running %0d done_count %0d done_at %0d want 6 1 7",
               run_cycles, done_count, done_at);
    end
  endtask

  task automatic test_div_change();
    logic [14:1] got_clk;
    logic [14:1] got_tick;
    bit seen;
    half_div = 16'd2;
    div_load = 1'b1;
    cycle();
    burst_len = 16'd0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 1) start = 1'b1;
      if (i == 2) begin
        half_div = 16'd3;
        div_load = 1'b1;
      end
      if (i == 6) begin
        half_div = 16'd0;
        div_load = 1'b1;
      end
      cycle();
      got_clk[i]  = clk_out;
      got_tick[i] = period_tick;
    end
    n_cmp++;
    if (got_clk !== 14'b01010001110011) begin
      n_err++;
      $display("[TB] FAIL div_change_clk: got %b want 01010001110011 (cycle 14..1)", got_clk);
    end
    n_cmp++;
    if (got_tick !== 14'b01010000010001) begin
      n_err++;
      $display("[TB] FAIL div_change_tick: got %b want 01010000010001 (cycle 14..1)", got_tick);
    end
    stop = 1'b1;
    wait_done(10, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL div_change_stop: done seen %b want 1", seen);
    end
  endtask

  task automatic test_stop();
    logic exp_clk;
    int done_count;
    bit seen;
    done_count = 0;
    half_div = 16'd4;
    div_load = 1'b1;
    cycle();
    burst_len = 16'd0;
    start = 1'b1;
    cycle();
    stop = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      cycle();
      if (done) done_count++;
      if (i <= 8) begin
        exp_clk = (i <= 4);
        n_cmp++;
        if (clk_out !== exp_clk || running !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL stop_period[%0d]: clk_out %b running %b want %b 1",
                   i, clk_out, running, exp_clk);
        end
      end else if (i == 9) begin
        n_cmp++;
        if (done !== 1'b1 || running !== 1'b0 || clk_out !== 1'b0) begin
          n_err++;
          $display("[TB] FAIL stop_done: done %b running %b clk_out %b want 1 0 0",
                   done, running, clk_out);
        end
      end
    end
    n_cmp++;
    if (done_count != 1) begin
      n_err++;
      $display("[TB] FAIL stop_done_count: got %0d want 1", done_count);
    end
    start = 1'b1;
    stop = 1'b1;
    cycle();
    n_cmp++;
    if (running !== 1'b1 || clk_out !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL start_beats_stop: running %b clk_out %b want 1 1", running, clk_out);
    end
    for (int i = 2; i <= 9; i++) cycle();
    n_cmp++;
    if (running !== 1'b1 || period_tick !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL start_beats_stop_2nd: running %b tick %b want 1 1", running, period_tick);
    end
    stop = 1'b1;
    wait_done(20, seen);
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("[TB] FAIL start_stop_end: done seen %b want 1", seen);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] obs;
    logic exp_clk;
    burst_len = 16'd0;
    start = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    obs = {clk_out, running, period_tick, done};
    n_cmp++;
    if (obs !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_mid_run: got %b want 0000", obs);
    end
    rst = 1'b0;
    burst_len = 16'd1;
    start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cycle();
      exp_clk = (i <= 8);
      n_cmp++;
      if (clk_out !== exp_clk) begin
        n_err++;
        $display("[TB] FAIL post_reset_half[%0d]: clk_out %b want %b", i, clk_out, exp_clk);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] obs;
    logic [3:0] expv;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 250) == 0;
      start     = ($urandom % 8) == 0;
      stop      = ($urandom % 40) == 0;
      div_load  = ($urandom % 12) == 0;
      half_div  = 16'($urandom % 5);
      burst_len = 16'($urandom % 4);
      cycle();
      rst  = 1'b0;
      obs  = {clk_out, running, period_tick, done};
      expv = model_vec();
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("[TB] FAIL random[%0d] {clk_out,running,tick,done}: got %b want %b", i, obs, expv);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    m_run     = 1'b0;
    m_pos     = 0;
    m_div     = DEF_HALF;
    m_pend    = DEF_HALF;
    m_periods = 0;
    m_burst   = 0;
    m_stopreq = 1'b0;
    m_done    = 1'b0;
    rst       = 1'b1;
    half_div  = 16'd0;
    div_load  = 1'b0;
    burst_len = 16'd0;
    start     = 1'b0;
    stop      = 1'b0;
    @(negedge clk);
    test_reset();
    test_continuous();
    test_burst();
    test_div_change();
    test_stop();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
